// File: rtl/alu_mul_div_seq.sv
// Sequencer for an unsigned 8x8 multiply and an 8/8 divide.
// Both operations share one 8-bit add/sub alu that is used once per iteration.
module alu_mul_div_seq #(
  parameter bit FAST_ZERO = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       op,
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic       busy,
  output logic       done,
  output logic [7:0] result_hi,
  output logic [7:0] result_lo,
  output logic       div_by_zero
);

  localparam int DATA_W = 8;

  typedef enum logic [1:0] {S_IDLE, S_ITER, S_ZERO, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [2:0]          cnt_q, cnt_d;
  logic                op_q, op_d;
  logic [DATA_W-1:0]   acc_q, acc_d;
  logic [DATA_W-1:0]   mq_q, mq_d;
  logic [DATA_W-1:0]   m_q, m_d;
  logic [DATA_W-1:0]   hi_q, hi_d;
  logic [DATA_W-1:0]   lo_q, lo_d;
  logic                dbz_q, dbz_d;

  logic [DATA_W-1:0]   div_t;
  logic [DATA_W-1:0]   alu_a;
  logic [DATA_W-1:0]   alu_r;
  logic                alu_c;
  logic [DATA_W-1:0]   mul_s;
  logic                mul_c;

  // For subtract, carry out = 1 means no borrow (x >= y).
  function automatic logic [DATA_W:0] alu_addsub(input logic [DATA_W-1:0] x,
                                                 input logic [DATA_W-1:0] y,
                                                 input logic sub);
    logic [DATA_W:0] res;
    if (sub) res = {1'b0, x} + {1'b0, ~y} + {{DATA_W{1'b0}}, 1'b1};
    else     res = {1'b0, x} + {1'b0, y};
    return res;
  endfunction

  // acc/mq hold the multiply accumulator and multiplier-quotient;
  // for divide they are the partial remainder and dividend-quotient.
  assign div_t          = {acc_q[DATA_W-2:0], mq_q[DATA_W-1]};
  assign alu_a          = op_q ? div_t : acc_q;
  assign {alu_c, alu_r} = alu_addsub(alu_a, m_q, op_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    acc_d   = acc_q;
    mq_d    = mq_q;
    m_d     = m_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    dbz_d   = dbz_q;
    mul_c   = 1'b0;
    mul_s   = acc_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (state_q == S_DONE) state_d = S_IDLE;
        if (start) begin
          op_d  = op;
          acc_d = '0;
          mq_d  = a;
          m_d   = b;
          cnt_d = '0;
          hi_d  = '0;
          lo_d  = '0;
          dbz_d = 1'b0;
          state_d = (FAST_ZERO && !op && (a == '0 || b == '0)) ? S_ZERO : S_ITER;
        end
      end
      S_ITER: begin
        if (!op_q) begin
          if (mq_q[0]) begin
            mul_c = alu_c;
            mul_s = alu_r;
          end
          acc_d = {mul_c, mul_s[DATA_W-1:1]};
          mq_d  = {mul_s[0], mq_q[DATA_W-1:1]};
        end else if (acc_q[DATA_W-1] | alu_c) begin
          acc_d = alu_r;
          mq_d  = {mq_q[DATA_W-2:0], 1'b1};
        end else begin
          acc_d = div_t;
          mq_d  = {mq_q[DATA_W-2:0], 1'b0};
        end
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          state_d = S_DONE;
          hi_d    = acc_d;
          lo_d    = mq_d;
          dbz_d   = op_q && (m_q == '0);
        end
      end
      S_ZERO: state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      dbz_q   <= dbz_d;
    end
  end

  always_ff @(posedge clk) begin
    op_q  <= op_d;
    acc_q <= acc_d;
    mq_q  <= mq_d;
    m_q   <= m_d;
  end

  assign busy        = (state_q == S_ITER);
  assign done        = (state_q == S_DONE);
  assign result_hi   = hi_q;
  assign result_lo   = lo_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_alu_mul_div_seq.sv
// Bench for alu_mul_div_seq: directed and random MUL/DIV checked against plain
// arithmetic, with one instance of each FAST_ZERO setting.
module tb_alu_mul_div_seq;

  logic       clk = 1'b0;
  logic       reset, start, start0, op;
  logic [7:0] a, b;
  logic       busy, done, dbz, busy0, done0, dbz0;
  logic [7:0] hi, lo, hi0, lo0;

  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_mul_div_seq #(.FAST_ZERO(1'b1)) u_dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result_hi(hi), .result_lo(lo), .div_by_zero(dbz)
  );

  alu_mul_div_seq #(.FAST_ZERO(1'b0)) u_dut0 (
    .clk(clk), .reset(reset), .start(start0), .op(op), .a(a), .b(b),
    .busy(busy0), .done(done0), .result_hi(hi0), .result_lo(lo0), .div_by_zero(dbz0)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One operation on the chosen instance; noise pulses start mid-iteration.
  task automatic run_op(input bit sel0, input bit o, input logic [7:0] x, input logic [7:0] y,
                        input bit noise, input string tag);
    logic [15:0] exp_res;
    logic        exp_dbz;
    int          exp_lat;
    int          lat;
    bit          d;
    if (o) begin
      if (y == 8'd0) exp_res = {x, 8'hFF};
      else           exp_res = {x % y, x / y};
    end else begin
      exp_res = {8'd0, x} * {8'd0, y};
    end
    exp_dbz = o && (y == 8'd0);
    exp_lat = (!sel0 && !o && (x == 8'd0 || y == 8'd0)) ? 1 : 8;

    @(negedge clk);
    op = o; a = x; b = y;
    if (sel0) start0 = 1'b1; else start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; start0 = 1'b0;
    check({tag, "_busy_acc"}, sel0 ? busy0 : busy, exp_lat > 1);
    check({tag, "_clr"}, sel0 ? {hi0, lo0, 7'd0, dbz0} : {hi, lo, 7'd0, dbz}, 32'd0);
    lat = 0;
    d = 1'b0;
    while (!d && lat < 20) begin
      if (noise && (lat == 2 || lat == 4)) begin
        op = ~o; a = ~x; b = y ^ 8'h5A;
        if (sel0) start0 = 1'b1; else start = 1'b1;
      end else begin
        start = 1'b0; start0 = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
      d = sel0 ? done0 : done;
    end
    start = 1'b0; start0 = 1'b0;
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_busy_done"}, sel0 ? busy0 : busy, 1'b0);
    check({tag, "_res"}, sel0 ? {hi0, lo0} : {hi, lo}, exp_res);
    check({tag, "_dbz"}, sel0 ? dbz0 : dbz, exp_dbz);
  endtask

  initial begin
    logic [7:0] ra, rb;
    bit         ro;
    reset = 1'b1; start = 1'b0; start0 = 1'b0; op = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_state", {busy, done, hi, lo, dbz}, 32'd0);
    check("rst_state0", {busy0, done0, hi0, lo0, dbz0}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    run_op(1'b0, 1'b0, 8'd13, 8'd11, 1'b0, "mul13x11");
    check("mul13x11_const", {hi, lo}, 16'h008F);
    run_op(1'b0, 1'b0, 8'd255, 8'd255, 1'b0, "mul255x255");
    check("mul255_const", {hi, lo}, 16'hFE01);
    run_op(1'b0, 1'b1, 8'd200, 8'd7, 1'b0, "div200by7");
    check("div200_const", {hi, lo, 7'd0, dbz}, {16'h041C, 8'd0});
    run_op(1'b0, 1'b1, 8'd255, 8'd1, 1'b0, "div255by1");
    check("div255_const", {hi, lo}, 16'h00FF);
    run_op(1'b0, 1'b1, 8'd100, 8'd0, 1'b0, "div100by0");
    check("divz_const", {hi, lo, 7'd0, dbz}, {16'h64FF, 8'd1});

    // Results hold in IDLE after DONE.
    @(posedge clk); #1;
    check("idle_after_done", {busy, done}, 2'b00);
    check("idle_hold", {hi, lo, 7'd0, dbz}, {16'h64FF, 8'd1});

    run_op(1'b0, 1'b1, 8'd77, 8'd9, 1'b1, "noise_div");
    run_op(1'b0, 1'b0, 8'd200, 8'd3, 1'b1, "noise_mul");

    // Reset on the 4th iteration edge discards the operation.
    @(negedge clk);
    op = 1'b0; a = 8'd200; b = 8'd200; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("pre_rst_busy", busy, 1'b1);
    reset = 1'b1;
    @(posedge clk); #1;
    check("mid_rst", {busy, done, hi, lo, dbz}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    check("mid_rst_stay_idle", {busy, done}, 2'b00);
    run_op(1'b0, 1'b0, 8'd3, 8'd5, 1'b0, "mul3x5");
    check("mul3x5_const", lo, 8'h0F);

    // Reset while holding results clears them.
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check("done_rst", {busy, done, hi, lo, dbz}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    run_op(1'b0, 1'b0, 8'd0, 8'd77, 1'b0, "fz_mul0x77");
    run_op(1'b0, 1'b0, 8'd45, 8'd0, 1'b0, "fz_mul45x0");
    run_op(1'b1, 1'b0, 8'd0, 8'd77, 1'b0, "nfz_mul0x77");
    run_op(1'b1, 1'b1, 8'd0, 8'd0, 1'b0, "nfz_div0by0");

    for (int i = 0; i < 40; i++) begin
      ro = 1'($urandom_range(0, 1));
      ra = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
      run_op(1'b0, ro, ra, rb, i[2], $sformatf("rnd%0d", i));
    end
    for (int i = 0; i < 10; i++) begin
      ro = 1'($urandom_range(0, 1));
      ra = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
      run_op(1'b1, ro, ra, rb, 1'b0, $sformatf("rnd0_%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
